tw_cpu: RTL and testbench
=========================

TW_CPU -- requirements
Module: tw_cpu

Interface
REQ-001 Parameter DATA_W, default 4: width of registers A, B, immediates, in and out; legal range 4..16.
REQ-002 Parameter ADDR_W, default 4: width of the program counter and imem_addr; legal range 4..16.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  ADDR_W  fetch address, equal to the PC.
REQ-007 imem_ack  input  1  fetch complete; imem_data valid this cycle.
REQ-008 imem_data  input  4+DATA_W  instruction: opcode in the upper 4 bits, imm in the lower DATA_W bits.
REQ-009 in  input  DATA_W  general input port, sampled in EXEC.
REQ-010 out  output  DATA_W  registered output port.
REQ-011 out_strobe  output  1  one-cycle pulse when out is written.
REQ-012 halted  output  1  high while in the HALT state.

Function
REQ-013 The FSM SHALL have three states:
  - FETCH: imem_req=1 and imem_addr=PC held stable; on imem_ack=1, latch imem_data into IR and go to EXEC; otherwise stay in FETCH, with unlimited wait states.
  - EXEC: execute IR for exactly one cycle, then go to FETCH; the HALT opcode goes to HALT instead.
  - HALT: imem_req=0; leave only by reset.
REQ-014 imem_ack SHALL be ignored outside FETCH.
REQ-015 Throughput with zero-wait memory (ack in the cycle req rises) SHALL be one instruction per 2 cycles.
REQ-016 In EXEC, the PC SHALL become PC+1 modulo 2^ADDR_W, unless a jump is taken.
REQ-017 Jump target SHALL be imm zero-extended (or truncated) to ADDR_W bits.
REQ-018 Opcodes:
  - 0000 A=A+imm
  - 0001 A=B
  - 0010 A=in
  - 0011 A=imm
  - 0100 B=A
  - 0101 B=B+imm
  - 0110 B=in
  - 0111 B=imm
  - 1000 A=A+B
  - 1001 out=B
  - 1010 HALT
  - 1011 out=imm
  - 1100 JC (jump if C=1)
  - 1101 NOP
  - 1110 JMP
  - 1111 JNC (jump if C=0)
REQ-019 Add opcodes (0000, 0101, 1000) SHALL compute at DATA_W+1 bits: C = carry-out, destination = low DATA_W bits, with modulo wrap.
REQ-020 Every non-add opcode SHALL clear C to 0 in EXEC; JC and JNC test C before it is cleared.
REQ-021 out_strobe SHALL be 1 in the cycle after EXEC of 1001 or 1011, and 0 otherwise.
REQ-022 out SHALL hold its value between writes.
REQ-023 Registers A, B, C, out SHALL change only at the end of an EXEC cycle.
REQ-024 The PC SHALL wrap from 2^ADDR_W-1 to 0 with no other side effect.
REQ-025 halted SHALL be 1 from the cycle after EXEC of HALT until reset.
REQ-026 While halted, A, B, C, out and PC SHALL hold their values.

Reset
REQ-027 While reset=0, regardless of clock, the block SHALL hold:
  - state=FETCH, PC=0, IR=0
  - A=B=C=0, out=0, out_strobe=0, halted=0
REQ-028 imem_req SHALL be 0 while reset=0, and SHALL rise in the first cycle after reset deasserts.
REQ-029 Reset asserted mid-fetch or mid-EXEC SHALL abort immediately; the pending ack is discarded and no register updates.
REQ-030 After reset, execution SHALL restart from address 0.

Verification
REQ-031 DATA_W=4, zero-wait memory, program 0011_1001 (A=9), 0000_1000 (A+=8) -> after the second EXEC A=1, C=1; next opcode 1111 (JNC) not taken, PC=3.
REQ-032 Memory acks 3 cycles after req -> imem_req and imem_addr stable across the wait; the instruction executes exactly once; IR is unchanged by spurious ack pulses asserted during EXEC.
REQ-033 Program at PC=2^ADDR_W-1 holding 1101 (NOP) -> next imem_addr=0, with no state change other than C=0.
REQ-034 Program 1011_0101 (out=5), then 1010 (HALT) -> out=5 with out_strobe high for exactly 1 cycle; halted=1 and imem_req=0 held for 20+ cycles.
REQ-035 reset pulled low for one cycle while in FETCH with ack pending -> all outputs are at reset values immediately; refetch from address 0 after release.
REQ-036 Parameter sweep DATA_W=8, ADDR_W=8, program 0111_11111111 (B=255), 0101_00000001 (B+=1) -> B=0, C=1; 1100 (JC) to 0x80 taken, imem_addr=0x80.

Source files
------------

// File: rtl/tw_cpu.sv
// tw_cpu: two-register accumulator CPU with a FETCH/EXEC/HALT control FSM and a
// request/acknowledge instruction-memory port. Carry is produced only by adds.
module tw_cpu #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W+3:0] imem_data,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              out_strobe,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_ADDA_IMM = 4'h0,
    OP_A_FROM_B = 4'h1,
    OP_A_FROM_IN = 4'h2,
    OP_A_IMM    = 4'h3,
    OP_B_FROM_A = 4'h4,
    OP_ADDB_IMM = 4'h5,
    OP_B_FROM_IN = 4'h6,
    OP_B_IMM    = 4'h7,
    OP_ADDA_B   = 4'h8,
    OP_OUT_B    = 4'h9,
    OP_HALT     = 4'hA,
    OP_OUT_IMM  = 4'hB,
    OP_JC       = 4'hC,
    OP_NOP      = 4'hD,
    OP_JMP      = 4'hE,
    OP_JNC      = 4'hF
  } op_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W+3:0]   ir_q;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                c_q, c_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                req_q;
  logic                strobe_q, strobe_d;
  logic                halted_q;
  logic                halt_d;

  op_e                 op;
  logic [DATA_W-1:0]   imm;

  function automatic logic [DATA_W:0] add_wide(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic [ADDR_W-1:0] jump_target(input logic [DATA_W-1:0] v);
    return ADDR_W'(v);
  endfunction

  assign op  = op_e'(ir_q[DATA_W+3:DATA_W]);
  assign imm = ir_q[DATA_W-1:0];

  // Execute-stage datapath: next register values for the instruction in IR.
  // C defaults to 0 so every non-add opcode clears it; jumps read c_q first.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    c_d      = 1'b0;
    out_d    = out_q;
    strobe_d = 1'b0;
    halt_d   = 1'b0;
    pc_d     = pc_q + ADDR_W'(1);
    case (op)
      OP_ADDA_IMM:  {c_d, a_d} = add_wide(a_q, imm);
      OP_A_FROM_B:  a_d = b_q;
      OP_A_FROM_IN: a_d = in;
      OP_A_IMM:     a_d = imm;
      OP_B_FROM_A:  b_d = a_q;
      OP_ADDB_IMM:  {c_d, b_d} = add_wide(b_q, imm);
      OP_B_FROM_IN: b_d = in;
      OP_B_IMM:     b_d = imm;
      OP_ADDA_B:    {c_d, a_d} = add_wide(a_q, b_q);
      OP_OUT_B: begin
        out_d    = b_q;
        strobe_d = 1'b1;
      end
      OP_HALT:      halt_d = 1'b1;
      OP_OUT_IMM: begin
        out_d    = imm;
        strobe_d = 1'b1;
      end
      OP_JC:        if (c_q) pc_d = jump_target(imm);
      OP_NOP:       ;
      OP_JMP:       pc_d = jump_target(imm);
      OP_JNC:       if (!c_q) pc_d = jump_target(imm);
      default:      ;
    endcase
  end

  // Control FSM with registered outputs. req_q is low in the first FETCH cycle
  // after reset, so an ack is only accepted once the request is visible.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      out_q    <= '0;
      req_q    <= 1'b0;
      strobe_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          req_q <= 1'b1;
          if (req_q && imem_ack) begin
            ir_q    <= imem_data;
            req_q   <= 1'b0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          a_q      <= a_d;
          b_q      <= b_d;
          c_q      <= c_d;
          out_q    <= out_d;
          pc_q     <= pc_d;
          strobe_q <= strobe_d;
          if (halt_d) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            req_q   <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_HALT: ;
        default: begin
          req_q   <= 1'b0;
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign out        = out_q;
  assign out_strobe = strobe_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_tw_cpu.sv
// Scoreboard bench for tw_cpu: a 4-bit/4-bit instance runs several directed
// programs and an 8-bit/8-bit instance runs the wide-parameter program.
module tb_tw_cpu;
  typedef int iq_t[$];

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, rst8;
  logic       req4, ack4, stb4, halt4;
  logic [3:0] addr4, in4, out4;
  logic [7:0] data4;
  logic        req8, ack8, stb8, halt8;
  logic [7:0]  addr8, in8, out8;
  logic [11:0] data8;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem4 [16];
  logic [11:0] mem8 [256];
  int   wait4 = 0;
  logic spur4 = 1'b0;
  int   exp_addr4[$], exp_out4[$], exp_addr8[$], exp_out8[$];

  tw_cpu #(.DATA_W(4), .ADDR_W(4)) dut4 (
    .clock(clk), .reset(rst4), .imem_req(req4), .imem_addr(addr4),
    .imem_ack(ack4), .imem_data(data4), .in(in4), .out(out4),
    .out_strobe(stb4), .halted(halt4)
  );

  tw_cpu #(.DATA_W(8), .ADDR_W(8)) dut8 (
    .clock(clk), .reset(rst8), .imem_req(req8), .imem_addr(addr8),
    .imem_ack(ack8), .imem_data(data8), .in(in8), .out(out8),
    .out_strobe(stb8), .halted(halt8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h, expected nothing (t=%0t)", name, act, $time);
  endtask

  // 4-bit instruction memory: configurable wait states, optional spurious acks
  // while the CPU is not requesting.
  initial begin
    int cnt;
    cnt = 0;
    ack4 = 1'b0;
    data4 = '0;
    forever begin
      @(negedge clk);
      if (rst4 === 1'b1 && req4 === 1'b1) begin
        if (cnt >= wait4) begin
          ack4 = 1'b1;
          data4 = mem4[addr4];
          cnt = 0;
        end else begin
          ack4 = 1'b0;
          data4 = 8'hBE;
          cnt++;
        end
      end else begin
        cnt = 0;
        ack4 = (rst4 === 1'b1) && spur4;
        data4 = 8'hB3;
      end
    end
  end

  initial begin
    ack8 = 1'b0;
    data8 = '0;
    forever begin
      @(negedge clk);
      ack8 = (rst8 === 1'b1) && (req8 === 1'b1);
      data8 = ack8 ? mem8[addr8] : 12'hBEE;
    end
  end

  // Monitor for the 4-bit instance
  initial begin
    logic prev_req, prev_acc, prev_spur;
    logic [3:0] held;
    logic [7:0] last_word;
    prev_req = 1'b0; prev_acc = 1'b0; prev_spur = 1'b0; held = '0; last_word = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst4 !== 1'b1) begin
        prev_req = 1'b0; prev_acc = 1'b0; prev_spur = 1'b0; last_word = '0;
      end else begin
        if (prev_spur) check("ir4_hold", dut4.ir_q, last_word);
        if (req4 && !prev_req) begin
          if (exp_addr4.size() == 0) flag("fetch4_unexpected", addr4);
          else check("fetch4_addr", addr4, exp_addr4.pop_front());
          held = addr4;
        end else if (req4) begin
          check("fetch4_addr_stable", addr4, held);
        end
        if (prev_req && !req4) check("fetch4_req_held_to_ack", prev_acc, 1);
        if (stb4) begin
          if (exp_out4.size() == 0) flag("out4_unexpected", out4);
          else check("out4_value", out4, exp_out4.pop_front());
        end
        prev_spur = !req4 && ack4;
        prev_acc = req4 && ack4;
        if (prev_acc) last_word = data4;
        prev_req = req4;
      end
    end
  end

  // Monitor for the 8-bit instance
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst8 !== 1'b1) begin
        prev_req = 1'b0;
      end else begin
        if (req8 && !prev_req) begin
          if (exp_addr8.size() == 0) flag("fetch8_unexpected", addr8);
          else check("fetch8_addr", addr8, exp_addr8.pop_front());
        end
        if (stb8) begin
          if (exp_out8.size() == 0) flag("out8_unexpected", out8);
          else check("out8_value", out8, exp_out8.pop_front());
        end
        prev_req = req8;
      end
    end
  end

  task automatic clear4();
    for (int i = 0; i < 16; i++) mem4[i] = 8'h00;
  endtask

  task automatic push4(input iq_t addrs, input iq_t outs);
    foreach (addrs[i]) exp_addr4.push_back(addrs[i]);
    foreach (outs[i]) exp_out4.push_back(outs[i]);
  endtask

  task automatic reset4();
    @(negedge clk);
    #1 rst4 = 1'b0;
    @(negedge clk);
    #1;
    check("rst4_req_low", req4, 0);
    check("rst4_addr", addr4, 0);
    check("rst4_out", out4, 0);
    check("rst4_halted", halt4, 0);
    rst4 = 1'b1;
    @(negedge clk);
    #3;
    check("rst4_req_rises", req4, 1);
  endtask

  task automatic wait_halt4(input string name);
    int n;
    n = 0;
    while (halt4 !== 1'b1 && n < 400) begin
      @(negedge clk);
      #3;
      n++;
    end
    check({name, "_halted"}, halt4, 1);
  endtask

  task automatic drain4(input string name);
    repeat (2) @(negedge clk);
    #3;
    check({name, "_fetches_left"}, exp_addr4.size(), 0);
    check({name, "_outs_left"}, exp_out4.size(), 0);
  endtask

  initial begin
    logic [3:0] held_addr;
    logic       hit;
    rst4 = 1'b0;
    rst8 = 1'b0;
    in4 = 4'h6;
    in8 = 8'h00;
    clear4();
    for (int i = 0; i < 256; i++) mem8[i] = 12'h000;
    #12;
    check("rst_req4", req4, 0);
    check("rst_stb4", stb4, 0);
    check("rst_halt4", halt4, 0);
    check("rst_out8", out8, 0);
    check("rst_req8", req8, 0);

    // P1: carry from A+imm, JNC not taken, JNC/JC taken, B=in, out=B
    mem4[0] = 8'h39; mem4[1] = 8'h08; mem4[2] = 8'hFA; mem4[3] = 8'h40;
    mem4[4] = 8'h90; mem4[5] = 8'hF7; mem4[7] = 8'h3F; mem4[8] = 8'h01;
    mem4[9] = 8'hCB; mem4[11] = 8'h60; mem4[12] = 8'h90; mem4[13] = 8'hD0;
    mem4[14] = 8'hA0;
    push4('{0, 1, 2, 3, 4, 5, 7, 8, 9, 11, 12, 13, 14}, '{1, 6});
    reset4();
    wait_halt4("p1");
    drain4("p1");

    // P2: three wait states, spurious acks outside fetch
    clear4();
    mem4[0] = 8'h73; mem4[1] = 8'h52; mem4[2] = 8'h10; mem4[3] = 8'h80;
    mem4[4] = 8'h40; mem4[5] = 8'h90; mem4[6] = 8'h20; mem4[7] = 8'h80;
    mem4[8] = 8'h40; mem4[9] = 8'h90; mem4[10] = 8'hB7; mem4[11] = 8'hA0;
    in4 = 4'h9;
    wait4 = 3;
    spur4 = 1'b1;
    push4('{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11}, '{10, 3, 7});
    reset4();
    wait_halt4("p2");
    drain4("p2");
    spur4 = 1'b0;
    wait4 = 0;

    // P3: PC wraps 15 -> 0 through a NOP that clears C
    clear4();
    mem4[0] = 8'hC4; mem4[1] = 8'h58; mem4[2] = 8'hC6; mem4[3] = 8'h3F;
    mem4[4] = 8'hEE; mem4[14] = 8'h01; mem4[15] = 8'hD0; mem4[6] = 8'h40;
    mem4[7] = 8'h90; mem4[8] = 8'hA0;
    push4('{0, 1, 2, 3, 4, 14, 15, 0, 1, 2, 6, 7, 8}, '{0});
    reset4();
    wait_halt4("p3");
    drain4("p3");

    // P4: out=5 then HALT; outputs must hold while halted
    clear4();
    mem4[0] = 8'hB5; mem4[1] = 8'hA0;
    push4('{0, 1}, '{5});
    reset4();
    wait_halt4("p4");
    held_addr = addr4;
    repeat (22) begin
      @(negedge clk);
      #3;
      check("halt4_halted", halt4, 1);
      check("halt4_req", req4, 0);
      check("halt4_out", out4, 5);
      check("halt4_strobe", stb4, 0);
      check("halt4_addr", addr4, held_addr);
    end
    drain4("p4");

    // P5: reset while an ack is pending, then restart from address 0
    wait4 = 3;
    push4('{0, 1, 0, 1}, '{5, 5});
    reset4();
    hit = 1'b0;
    for (int n = 0; n < 60 && !hit; n++) begin
      @(negedge clk);
      #1;
      if (req4 === 1'b1 && ack4 === 1'b1 && addr4 === 4'd1) hit = 1'b1;
    end
    check("p5_ack_pending_seen", hit, 1);
    rst4 = 1'b0;
    #1;
    check("p5_rst_req", req4, 0);
    check("p5_rst_addr", addr4, 0);
    check("p5_rst_out", out4, 0);
    check("p5_rst_strobe", stb4, 0);
    check("p5_rst_halted", halt4, 0);
    check("p5_rst_ir", dut4.ir_q, 0);
    @(negedge clk);
    #1 rst4 = 1'b1;
    wait_halt4("p5");
    drain4("p5");
    wait4 = 0;

    // P6: DATA_W=8/ADDR_W=8: B=255, B+=1 wraps with carry, JC to 0x80
    mem8[0] = 12'h7FF; mem8[1] = 12'h501; mem8[2] = 12'hC80;
    mem8[128] = 12'h900; mem8[129] = 12'h503; mem8[130] = 12'h900; mem8[131] = 12'hA00;
    exp_addr8 = '{0, 1, 2, 128, 129, 130, 131};
    exp_out8 = '{0, 3};
    @(negedge clk);
    #1 rst8 = 1'b1;
    for (int n = 0; n < 200 && halt8 !== 1'b1; n++) begin
      @(negedge clk);
      #3;
    end
    check("p6_halted", halt8, 1);
    repeat (2) @(negedge clk);
    #3;
    check("p6_fetches_left", exp_addr8.size(), 0);
    check("p6_outs_left", exp_out8.size(), 0);
    check("p6_req_after_halt", req8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
